// File: rtl/memwrite_trace_streamer_pkg.sv
// Shared types and constants for the store trace streamer.
// Record headers, FSM states and the buffered store record.
package memwrite_trace_streamer_pkg;

  localparam logic [7:0] HDR_STORE = 8'hA5;
  localparam logic [7:0] HDR_END   = 8'h5A;
  localparam int         REC_BYTES = 9;
  localparam logic [3:0] LAST_IDX  = 4'(REC_BYTES - 1);

  typedef enum logic [1:0] {
    RUN,
    SEND,
    END_SEND,
    DONE
  } trace_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_rec_t;

endpackage

// File: rtl/memwrite_trace_streamer_if.sv
// Byte stream valid/ready interface.
// Master drives data/valid, slave drives ready.
interface memwrite_trace_streamer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/memwrite_trace_streamer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Push while full and pop while empty are ignored.
module memwrite_trace_streamer_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         wr_en;
  logic         rd_en;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update; wrap bit distinguishes full from empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/memwrite_trace_streamer.sv
// Snoops core stores and serialises them as 9-byte records.
// Emits one END record with final pc and store count.
module memwrite_trace_streamer
  import memwrite_trace_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic [31:0] pc,
  input  logic [31:0] pc_finished,
  memwrite_trace_streamer_if.master tx,
  output logic        overflow,
  output logic        done
);

  trace_state_t     state_q;
  store_rec_t       head;
  logic [63:0]      shreg_q;
  logic [3:0]       idx_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             done_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin;
  logic             cap;
  logic             accept;
  logic             pop;
  logic             full;
  logic             empty;

  assign fin    = (pc == pc_finished);
  assign cap    = memwrite && !fin &&
                  (state_q == RUN || state_q == SEND);
  assign accept = cap && !full;
  assign pop    = (state_q == RUN) && !empty;

  memwrite_trace_streamer_sync_fifo #(
    .W     ($bits(store_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (cap),
    .pop_i   (pop),
    .din_i   ({aluout, writedata}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Store count saturates; a full FIFO drops and flags.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cap && full) ovf_d = 1'b1;
    if (accept && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Record sequencer: header first, then payload MSB first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      shreg_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!empty) begin
            shreg_q <= head;
            idx_q   <= '0;
            data_q  <= HDR_STORE;
            valid_q <= 1'b1;
            state_q <= SEND;
          end else if (fin) begin
            shreg_q <= {pc, 32'(cnt_q)};
            idx_q   <= '0;
            data_q  <= HDR_END;
            valid_q <= 1'b1;
            state_q <= END_SEND;
          end
        end
        SEND, END_SEND: begin
          if (tx.tx_ready) begin
            if (idx_q == LAST_IDX) begin
              valid_q <= 1'b0;
              idx_q   <= '0;
              if (state_q == END_SEND) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RUN;
              end
            end else begin
              data_q  <= shreg_q[63:56];
              shreg_q <= {shreg_q[55:0], 8'h00};
              idx_q   <= idx_q + 4'd1;
            end
          end
        end
        DONE: done_q <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign overflow    = ovf_q;
  assign done        = done_q;

endmodule

// File: tb/tb_memwrite_trace_streamer.sv
// Bench for memwrite_trace_streamer.
// Directed scenarios plus random traffic against a queue model.
module tb_memwrite_trace_streamer;

  localparam int DEPTH = 8;
  localparam logic [31:0] PC_FIN = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic [31:0] pc = 32'h40;
  logic [31:0] pc_finished = PC_FIN;
  logic        overflow;
  logic        done;

  memwrite_trace_streamer_if tx_if();

  memwrite_trace_streamer #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .aluout      (aluout),
    .writedata   (writedata),
    .pc          (pc),
    .pc_finished (pc_finished),
    .tx          (tx_if),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending records, record in flight, flags.
  logic [63:0] m_q[$];
  logic [7:0]  m_rec[9];
  logic [63:0] m_pay;
  bit          m_busy, m_end, m_done, m_ovf, m_fin, m_cap;
  int          m_idx, m_pre;
  logic [31:0] m_cnt;

  initial begin
    m_busy = 0; m_end = 0; m_done = 0; m_ovf = 0;
    m_idx = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_busy = 0; m_end = 0; m_done = 0; m_ovf = 0;
      m_idx = 0; m_cnt = 0;
    end else begin
      m_fin = (pc == pc_finished);
      m_cap = memwrite && !m_fin && !m_end;
      m_pre = m_q.size();
      if (m_busy) begin
        if (tx_if.tx_ready) begin
          if (m_idx == 8) begin
            m_busy = 0;
            if (m_end) m_done = 1;
          end else m_idx++;
        end
      end else if (!m_end && (m_pre > 0 || m_fin)) begin
        if (m_pre > 0) begin
          m_pay = m_q.pop_front();
          m_rec[0] = 8'hA5;
        end else begin
          m_pay = {pc, m_cnt};
          m_rec[0] = 8'h5A;
          m_end = 1;
        end
        for (int b = 0; b < 8; b++)
          m_rec[b+1] = m_pay[63-8*b -: 8];
        m_busy = 1;
        m_idx = 0;
      end
      if (m_cap) begin
        if (m_pre == DEPTH) m_ovf = 1;
        else begin
          m_q.push_back({aluout, writedata});
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
      end
    end
  end

  logic [31:0] tail = '0;

  // Continuous comparison against the model, away from posedge.
  always @(negedge clk) begin
    check("tx_valid", {31'd0, tx_if.tx_valid}, {31'd0, m_busy});
    if (m_busy)
      check("tx_data", {24'd0, tx_if.tx_data},
            {24'd0, m_rec[m_idx]});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("done", {31'd0, done}, {31'd0, m_done});
    if (tx_if.tx_valid && tx_if.tx_ready)
      tail = {tail[23:0], tx_if.tx_data};
  end

  task automatic store(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1;
    aluout = a;
    writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    logic [7:0] exp1[9];
    tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_if.tx_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    tx_if.tx_ready = 1'b1;

    // single store, exact bytes and latency
    store(32'h54, 32'h7);
    check("t1_lat", {31'd0, tx_if.tx_valid}, 32'd0);
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h54,
             8'h00, 8'h00, 8'h00, 8'h07};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_valid", {31'd0, tx_if.tx_valid}, 32'd1);
      check("t1_byte", {24'd0, tx_if.tx_data}, {24'd0, exp1[i]});
    end

    // backpressure mid-record
    repeat (2) @(negedge clk);
    store(32'h1122_3344, 32'h5566_7788);
    repeat (3) @(negedge clk);
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold", {24'd0, tx_if.tx_data}, 32'h22);
      check("t2_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    end
    tx_if.tx_ready = 1'b1;
    repeat (10) @(negedge clk);

    // burst overflow with sink stalled
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memwrite = 1'b1;
      aluout = 32'h1000 + 32'(i);
      writedata = 32'hD000 + 32'(i);
    end
    @(negedge clk);
    memwrite = 1'b0;
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    tx_if.tx_ready = 1'b1;
    repeat (110) @(negedge clk);

    // finish: three stores then a gated store at pc_finished
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memwrite = 1'b1;
      aluout = $urandom;
      writedata = $urandom;
    end
    @(negedge clk);
    pc = PC_FIN;
    aluout = 32'hDEAD_0000;
    @(negedge clk);
    memwrite = 1'b0;
    for (int c = 0; c < 100 && !done; c++) @(negedge clk);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_count", tail, 32'd3);

    // reset mid-record
    @(negedge clk); reset = 1'b0; pc = 32'h40;
    @(negedge clk); reset = 1'b1;
    store(32'hABCD, 32'h1234);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    store(32'hCAFE_0000, 32'h99);
    check("t5_lat", {31'd0, tx_if.tx_valid}, 32'd0);
    @(negedge clk);
    check("t5_hdr", {24'd0, tx_if.tx_data}, 32'hA5);
    check("t5_hvalid", {31'd0, tx_if.tx_valid}, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      memwrite = ($urandom_range(0, 9) < 4);
      aluout = $urandom;
      writedata = $urandom;
      pc = $urandom & 32'hFFFF_FEFF;
      tx_if.tx_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    memwrite = 1'b0;
    tx_if.tx_ready = 1'b1;
    pc = PC_FIN;
    for (int c = 0; c < 400 && !done; c++) @(negedge clk);
    check("rnd_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
